// File: rtl/avst_pkt_accum_if.sv
// avst_pkt_accum_if: input and output stream signals of the packet accumulator
interface avst_pkt_accum_if #(
  parameter int DATA_W = 8,
  parameter int ACC_W = 16,
  parameter int CH_W = 2,
  parameter int LEN_W = 8
);
  logic [DATA_W-1:0] data_in;
  logic [CH_W-1:0] channel_in;
  logic end_in;
  logic mode_in;
  logic valid_in;
  logic ready_in;
  logic [ACC_W-1:0] data_out;
  logic [CH_W-1:0] channel_out;
  logic end_out;
  logic [LEN_W-1:0] len_out;
  logic ovf_out;
  logic valid_out;
  logic ready_out;
  logic err_out;
  modport master (
    output data_in, channel_in, end_in, mode_in, valid_in, ready_out,
    input ready_in, data_out, channel_out, end_out, len_out, ovf_out, valid_out, err_out
  );
  modport slave (
    input data_in, channel_in, end_in, mode_in, valid_in, ready_out,
    output ready_in, data_out, channel_out, end_out, len_out, ovf_out, valid_out, err_out
  );
endinterface

// File: rtl/avst_pkt_accum.sv
// avst_pkt_accum: multi-channel Avalon-ST packet accumulator with output FIFO
module avst_pkt_accum #(
  parameter int DATA_W = 8,
  parameter int ACC_W = 16,
  parameter int NUM_CH = 4,
  parameter int CH_W = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int LEN_W = 8,
  parameter int SATURATE = 0
) (
  input logic clk,
  input logic reset,
  avst_pkt_accum_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int NS = 1 << CH_W;
  typedef struct packed {
    logic [ACC_W-1:0] d;
    logic [CH_W-1:0] c;
    logic e;
    logic [LEN_W-1:0] l;
    logic o;
  } ent_t;
  // state slots cover the whole channel field; only legal channels are ever written
  logic [ACC_W-1:0] acc [NS];
  logic [LEN_W-1:0] len [NS];
  logic [NS-1:0] ovf, sop;
  ent_t mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt, cnt_nx;
  logic rdy, err, legal, take, push, pop, c, o;
  logic [CH_W-1:0] ch;
  logic [ACC_W-1:0] base, sum;
  logic [ACC_W:0] s;
  logic [LEN_W-1:0] l;
  always_comb begin
    ch = bus.channel_in;
    legal = 32'(ch) < NUM_CH;
    take = bus.valid_in & rdy & legal;
    push = take & (bus.end_in | bus.mode_in);
    pop = (cnt != '0) & bus.ready_out;
    base = sop[ch] ? '0 : acc[ch];
    s = {1'b0, base} + (ACC_W+1)'(bus.data_in);
    c = s[ACC_W];
    sum = (SATURATE != 0 && c) ? '1 : s[ACC_W-1:0];
    o = (!sop[ch] & ovf[ch]) | c;
    l = sop[ch] ? LEN_W'(1) : len[ch] + LEN_W'(len[ch] != '1);
    cnt_nx = cnt + (AW+1)'(push) - (AW+1)'(pop);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NS; i++) begin
        acc[i] <= '0;
        len[i] <= '0;
      end
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      ovf <= '0;
      sop <= '1;
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      rdy <= 1'b0;
      err <= 1'b0;
    end else begin
      rdy <= cnt_nx != (AW+1)'(FIFO_DEPTH);
      err <= bus.valid_in & rdy & !legal;
      cnt <= cnt_nx;
      if (take) begin
        acc[ch] <= sum;
        len[ch] <= l;
        ovf[ch] <= o;
        sop[ch] <= bus.end_in;
      end
      if (push) begin
        mem[wp] <= '{d: sum, c: ch, e: bus.end_in, l: l, o: o};
        wp <= wp + 1'b1;
      end
      if (pop) rp <= rp + 1'b1;
    end
  end
  assign bus.ready_in = rdy;
  assign bus.err_out = err;
  assign bus.valid_out = cnt != '0;
  assign {bus.data_out, bus.channel_out, bus.end_out, bus.len_out, bus.ovf_out} = mem[rp];
endmodule

// File: doc/avst_pkt_accum.md
Name: avst_pkt_accum

Overview:
- Parametrised Avalon-ST successor to the single-channel 8-bit adder.
- Accumulates beats of each packet, with multiple interleaved channels, into a wide per-channel sum.
- Emits either one sum per packet (total mode) or a running partial sum per beat (running mode).
- An output FIFO decouples the input from downstream backpressure.
- Sits between an Avalon-ST source and sink in the streaming datapath.

Parameters:
- DATA_W, 8: input beat width.
- ACC_W, 16: accumulator/output width, must be >= DATA_W.
- NUM_CH, 4: number of channels, at least 2.
- CH_W, 2: channel field width, must be >= clog2(NUM_CH).
- FIFO_DEPTH, 4: output FIFO entries, power of two, at least 2.
- LEN_W, 8: packet beat-count width.
- SATURATE, 0: 0 means the sum wraps mod 2^ACC_W; 1 means the sum clamps at 2^ACC_W-1.

Ports:
- clk, in, 1: clock; all logic on the rising edge.
- reset, in, 1: asynchronous, active-high reset.
- data_in, in, DATA_W: input beat data, unsigned.
- channel_in, in, CH_W: channel of the input beat.
- end_in, in, 1: last beat of the packet.
- mode_in, in, 1: 0 = total, 1 = running; sampled per accepted beat.
- valid_in, in, 1: input beat valid.
- ready_in, out, 1: block can accept a beat.
- data_out, out, ACC_W: sum.
- channel_out, out, CH_W: channel of the sum.
- end_out, out, 1: entry closes its packet.
- len_out, out, LEN_W: beats so far in the packet, including this one.
- ovf_out, out, 1: packet overflowed ACC_W at or before this beat.
- valid_out, out, 1: output entry valid.
- ready_out, in, 1: sink accepts the entry.
- err_out, out, 1: one-cycle pulse when a beat with an illegal channel is accepted.

Behaviour:
- Reset (async assert):
  - FIFO empty.
  - All acc[ch] = 0, len[ch] = 0, ovf[ch] = 0, sop[ch] = 1.
  - Outputs: valid_out 0, data_out 0, channel_out 0, end_out 0, len_out 0, ovf_out 0, err_out 0, ready_in 0.
  - ready_in goes to 1 on the first clk edge after reset deasserts.
  - Reset mid-packet discards the partial packet; the next beat on any channel starts a new packet.
- Accept = valid_in & ready_in.
  - ready_in = !reset & (fifo_count != FIFO_DEPTH), driven from registers only; it never depends on valid_in.
- Illegal channel (channel_in >= NUM_CH): beat accepted, no state change, nothing pushed, err_out = 1 next cycle.
- Legal accepted beat, ch = channel_in:
  - base = sop[ch] ? 0 : acc[ch].
  - s = base + zero-extended data_in, computed at ACC_W+1 bits.
  - c = carry bit of s.
  - sum = SATURATE & c ? all-ones : s[ACC_W-1:0].
  - o = (sop[ch] ? 0 : ovf[ch]) | c.
  - l = sop[ch] ? 1 : min(len[ch]+1, 2^LEN_W-1), saturating.
  - Registers update to acc[ch]=sum, ovf[ch]=o, len[ch]=l, sop[ch]=end_in.
  - When SATURATE=1, a clamped acc[ch] keeps clamping on further beats.
- Push: on accept with end_in | mode_in, write {sum, ch, end_in, l, o} into the FIFO.
  - Total-mode non-end beats push nothing.
- Output:
  - valid_out = fifo_count != 0; data/channel/end/len/ovf_out show the FIFO head.
  - Pop on valid_out & ready_out.
  - A pushed entry is visible on the outputs the cycle after the accept edge; first-word latency is 1 cycle.
- Simultaneous push and pop: count unchanged, pointers both advance.
  - No push when full, because ready_in = 0.
  - Pop when empty is impossible.
- Ordering:
  - Output order equals push order across all channels.
  - Channels interleave freely beat by beat, with independent state per channel.
- Outputs are stable while valid_out & !ready_out. When empty (valid_out = 0), the out fields are don't-care.

Test Plan:
1. Reset, then idle.
   - Required: ready_in = 1 and valid_out = 0 one edge after reset drops.
   - Required: err_out never pulses.
2. Total mode, ch0 beats 10, 20, 30 (end on 30).
   - Required: exactly one entry, data_out=60, channel_out=0, end_out=1, len_out=3, ovf_out=0.
   - Required: valid_out rises one cycle after the 30 is accepted.
3. Interleave, total mode: ch1 200, ch2 5, ch1 100 (end), ch2 7 (end).
   - Required: {300, ch1, len 2} then {12, ch2, len 2}, in that order.
4. Running mode, ch3 beats 1, 2, 3 (end), then ch3 4 (end).
   - Required: outputs 1/2/3 with end 0/0/1 and sums 1, 3, 6; len 1/2/3.
   - Required: then 4 with end 1, len 1 (new packet).
5. Overflow, ACC_W=9, total mode, ch0 beats 255, 255, 255 (end).
   - SATURATE=0: data_out=253, ovf_out=1.
   - SATURATE=1: data_out=511, ovf_out=1.
   - Required: a following single-beat packet 5 gives data_out=5, ovf_out=0.
6. Backpressure and reset, ready_out=0, FIFO_DEPTH=4.
   - Send 5 single-beat end packets, 1 through 5.
   - Required: ready_in drops after the 4th accept; the 5th beat is held.
   - Raise ready_out: required outputs 1, 2, 3, 4, 5 in order, with ready_in back to 1 the cycle after the first pop.
   - Then send ch0 9, 9 (no end), pulse reset, send ch0 7 (end): required single output 7, len_out=1.
   - Then send one beat with channel_in = NUM_CH: required err_out pulse and no output.
